// File: rtl/mc_host_arb.sv
// mc_host_arb: two-requester round-robin arbiter in front of the single host
// port of the HyperRAM memory controller. The winning requester's command is
// registered and presented to the controller; write/read data is routed to and
// from the owner and counted so the port is released at transaction end.
module mc_host_arb #(
  parameter int unsigned BURST_WORDS = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_rwn,
  input  logic        m0_burst,
  input  logic [31:0] m0_addr,
  output logic        m0_ack,
  input  logic [1:0]  m0_txm,
  input  logic [15:0] m0_txd,
  output logic        m0_txd_ack,
  output logic [15:0] m0_rxd,
  output logic        m0_rxd_vld,

  input  logic        m1_req,
  input  logic        m1_rwn,
  input  logic        m1_burst,
  input  logic [31:0] m1_addr,
  output logic        m1_ack,
  input  logic [1:0]  m1_txm,
  input  logic [15:0] m1_txd,
  output logic        m1_txd_ack,
  output logic [15:0] m1_rxd,
  output logic        m1_rxd_vld,

  output logic        mc_req,
  output logic        mc_rwn,
  output logic        mc_burst,
  output logic [31:0] mc_addr,
  input  logic        mc_ack,
  output logic [1:0]  mc_txm,
  output logic [15:0] mc_txd,
  input  logic        mc_txd_ack,
  input  logic [15:0] mc_rxd,
  input  logic        mc_rxd_vld,

  output logic        owner,
  output logic        busy,
  output logic        proto_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;

  localparam logic [CNT_W-1:0] CNT_BURST  = CNT_W'(BURST_WORDS);
  localparam logic [CNT_W-1:0] CNT_SINGLE = CNT_W'(1);

  logic [1:0]       state;
  logic             last;
  logic             owner_q;
  logic [CNT_W-1:0] cnt;
  logic             proto_err_q;
  logic             rwn_q;
  logic             burst_q;
  logic [31:0]      addr_q;

  logic             gnt_vld;
  logic             gnt;
  logic             gnt_rwn;
  logic             gnt_burst;
  logic [31:0]      gnt_addr;

  logic             wr_ev;
  logic             rd_ev;
  logic             data_ev;
  logic             bad_ev;

  // Round-robin grant decision and selection of the winner's command fields.
  always_comb begin
    gnt_vld = m0_req | m1_req;
    if (m0_req && m1_req) begin
      gnt = ~last;
    end else begin
      gnt = m1_req;
    end
    gnt_rwn   = gnt ? m1_rwn   : m0_rwn;
    gnt_burst = gnt ? m1_burst : m0_burst;
    gnt_addr  = gnt ? m1_addr  : m0_addr;
  end

  // Classify controller data events: only direction-matching events in XFER count.
  always_comb begin
    wr_ev   = (state == XFER) && !rwn_q && mc_txd_ack;
    rd_ev   = (state == XFER) &&  rwn_q && mc_rxd_vld;
    data_ev = wr_ev | rd_ev;
    bad_ev  = (mc_ack && (state != CMD)) ||
              (mc_txd_ack && !wr_ev) ||
              (mc_rxd_vld && !rd_ev);
  end

  // Arbitration FSM, registered command and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner_q <= 1'b0;
      cnt     <= '0;
      rwn_q   <= 1'b1;
      burst_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            owner_q <= gnt;
            last    <= gnt;
            rwn_q   <= gnt_rwn;
            burst_q <= gnt_burst;
            addr_q  <= gnt_addr;
            cnt     <= gnt_burst ? CNT_BURST : CNT_SINGLE;
            state   <= CMD;
          end
        end
        CMD: begin
          if (mc_ack) begin
            state <= XFER;
          end
        end
        XFER: begin
          if (data_ev) begin
            if (cnt == CNT_SINGLE) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - CNT_SINGLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky protocol-violation flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (bad_ev) begin
      proto_err_q <= 1'b1;
    end
  end

  // Route handshakes and write data between the owner and the controller.
  always_comb begin
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    m0_txd_ack = 1'b0;
    m1_txd_ack = 1'b0;
    m0_rxd_vld = 1'b0;
    m1_rxd_vld = 1'b0;
    mc_txd     = '0;
    mc_txm     = '0;

    if (state == CMD && mc_ack) begin
      m0_ack = ~owner_q;
      m1_ack =  owner_q;
    end
    if (wr_ev) begin
      m0_txd_ack = ~owner_q;
      m1_txd_ack =  owner_q;
    end
    if (rd_ev) begin
      m0_rxd_vld = ~owner_q;
      m1_rxd_vld =  owner_q;
    end
    if (state != IDLE) begin
      mc_txd = owner_q ? m1_txd : m0_txd;
      mc_txm = owner_q ? m1_txm : m0_txm;
    end
  end

  assign m0_rxd    = mc_rxd;
  assign m1_rxd    = mc_rxd;

  assign mc_req    = (state == CMD);
  assign mc_rwn    = rwn_q;
  assign mc_burst  = burst_q;
  assign mc_addr   = addr_q;

  assign owner     = owner_q;
  assign busy      = (state != IDLE);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mc_host_arb.sv
// Directed testbench for mc_host_arb. The bench plays the controller side by
// hand; all stimulus is applied and outputs sampled 1-2 ns after the rising edge.
module tb_mc_host_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_req = 1'b0, m0_rwn = 1'b0, m0_burst = 1'b0;
  logic [31:0] m0_addr = '0;
  logic [1:0]  m0_txm = '0;
  logic [15:0] m0_txd = '0;
  logic        m0_ack, m0_txd_ack, m0_rxd_vld;
  logic [15:0] m0_rxd;

  logic        m1_req = 1'b0, m1_rwn = 1'b0, m1_burst = 1'b0;
  logic [31:0] m1_addr = '0;
  logic [1:0]  m1_txm = '0;
  logic [15:0] m1_txd = '0;
  logic        m1_ack, m1_txd_ack, m1_rxd_vld;
  logic [15:0] m1_rxd;

  logic        mc_req, mc_rwn, mc_burst;
  logic [31:0] mc_addr;
  logic [1:0]  mc_txm;
  logic [15:0] mc_txd;
  logic        mc_ack = 1'b0, mc_txd_ack = 1'b0, mc_rxd_vld = 1'b0;
  logic [15:0] mc_rxd = '0;

  logic        owner, busy, proto_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  mc_host_arb #(.BURST_WORDS(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rwn(m0_rwn), .m0_burst(m0_burst), .m0_addr(m0_addr),
    .m0_ack(m0_ack), .m0_txm(m0_txm), .m0_txd(m0_txd), .m0_txd_ack(m0_txd_ack),
    .m0_rxd(m0_rxd), .m0_rxd_vld(m0_rxd_vld),
    .m1_req(m1_req), .m1_rwn(m1_rwn), .m1_burst(m1_burst), .m1_addr(m1_addr),
    .m1_ack(m1_ack), .m1_txm(m1_txm), .m1_txd(m1_txd), .m1_txd_ack(m1_txd_ack),
    .m1_rxd(m1_rxd), .m1_rxd_vld(m1_rxd_vld),
    .mc_req(mc_req), .mc_rwn(mc_rwn), .mc_burst(mc_burst), .mc_addr(mc_addr),
    .mc_ack(mc_ack), .mc_txm(mc_txm), .mc_txd(mc_txd), .mc_txd_ack(mc_txd_ack),
    .mc_rxd(mc_rxd), .mc_rxd_vld(mc_rxd_vld),
    .owner(owner), .busy(busy), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"},      32'(busy), 32'd0);
    check({tag, ".mc_req"},    32'(mc_req), 32'd0);
    check({tag, ".mc_rwn"},    32'(mc_rwn), 32'd1);
    check({tag, ".mc_burst"},  32'(mc_burst), 32'd0);
    check({tag, ".mc_addr"},   mc_addr, 32'd0);
    check({tag, ".owner"},     32'(owner), 32'd0);
    check({tag, ".proto_err"}, 32'(proto_err), 32'd0);
    check({tag, ".acks"},      32'({m0_ack, m1_ack, m0_txd_ack, m1_txd_ack}), 32'd0);
    check({tag, ".vlds"},      32'({m0_rxd_vld, m1_rxd_vld}), 32'd0);
    check({tag, ".mc_txd"},    32'(mc_txd), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_txd;
    logic        exp_own;

    // ---------------- reset ----------------
    tick(); tick();
    rst = 1'b0;
    settle();
    check_reset_outputs("rst");

    // ---------------- m0 single write ----------------
    m0_req = 1'b1; m0_rwn = 1'b0; m0_burst = 1'b0;
    m0_addr = 32'h100; m0_txd = 16'hA5A5; m0_txm = 2'b11;
    settle();
    check("wr.mc_req_pre", 32'(mc_req), 32'd0);
    tick();                                     // grant edge -> CMD
    check("wr.mc_req",   32'(mc_req), 32'd1);
    check("wr.owner",    32'(owner), 32'd0);
    check("wr.mc_addr",  mc_addr, 32'h100);
    check("wr.mc_rwn",   32'(mc_rwn), 32'd0);
    check("wr.busy",     32'(busy), 32'd1);
    mc_ack = 1'b1; settle();
    check("wr.m0_ack",   32'(m0_ack), 32'd1);
    check("wr.m1_ack",   32'(m1_ack), 32'd0);
    tick();                                     // -> XFER
    mc_ack = 1'b0; m0_req = 1'b0; settle();
    check("wr.mc_req_x", 32'(mc_req), 32'd0);
    check("wr.mc_txd",   32'(mc_txd), 32'hA5A5);
    check("wr.mc_txm",   32'(mc_txm), 32'd3);
    mc_txd_ack = 1'b1; settle();
    check("wr.m0_txd_ack", 32'(m0_txd_ack), 32'd1);
    check("wr.m1_outs",  32'({m1_ack, m1_txd_ack, m1_rxd_vld}), 32'd0);
    tick();                                     // -> IDLE
    mc_txd_ack = 1'b0; settle();
    check("wr.busy_end", 32'(busy), 32'd0);
    check("wr.txd_idle", 32'(mc_txd), 32'd0);
    check("wr.perr",     32'(proto_err), 32'd0);

    // ---------------- m1 burst read ----------------
    m1_req = 1'b1; m1_rwn = 1'b1; m1_burst = 1'b1; m1_addr = 32'h2000;
    tick();                                     // -> CMD
    check("rd.owner",    32'(owner), 32'd1);
    check("rd.mc_burst", 32'(mc_burst), 32'd1);
    check("rd.mc_addr",  mc_addr, 32'h2000);
    check("rd.mc_rwn",   32'(mc_rwn), 32'd1);
    mc_ack = 1'b1; settle();
    check("rd.m1_ack",   32'(m1_ack), 32'd1);
    check("rd.m0_ack",   32'(m0_ack), 32'd0);
    tick();
    mc_ack = 1'b0; m1_req = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      mc_rxd = 16'(k); mc_rxd_vld = 1'b1; settle();
      check("rd.busy",     32'(busy), 32'd1);
      check("rd.m1_vld",   32'(m1_rxd_vld), 32'd1);
      check("rd.m1_rxd",   32'(m1_rxd), k);
      check("rd.m0_rxd",   32'(m0_rxd), k);
      check("rd.m0_vld",   32'(m0_rxd_vld), 32'd0);
      tick();
    end
    mc_rxd_vld = 1'b0; settle();
    check("rd.busy_end", 32'(busy), 32'd0);
    check("rd.perr",     32'(proto_err), 32'd0);

    // ---------------- fairness from reset ----------------
    rst = 1'b1; tick(); rst = 1'b0;
    m0_txd = 16'h1111; m1_txd = 16'h2222;
    m0_rwn = 1'b0; m1_rwn = 1'b0; m0_burst = 1'b0; m1_burst = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int unsigned t = 0; t < 4; t++) begin
      exp_own = t[0];
      exp_txd = exp_own ? 16'h2222 : 16'h1111;
      tick();                                   // grant -> CMD
      check("rr.owner",  32'(owner), 32'(exp_own));
      check("rr.mc_req", 32'(mc_req), 32'd1);
      mc_ack = 1'b1; settle();
      check("rr.ack",    32'({m0_ack, m1_ack}), exp_own ? 32'd1 : 32'd2);
      tick();
      mc_ack = 1'b0; settle();
      check("rr.mc_txd", 32'(mc_txd), 32'(exp_txd));
      mc_txd_ack = 1'b1;
      tick();                                   // -> IDLE
      mc_txd_ack = 1'b0; settle();
      check("rr.idle",   32'(busy), 32'd0);
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // ---------------- m1 waits behind m0 burst write ----------------
    m0_req = 1'b1; m0_rwn = 1'b0; m0_burst = 1'b1; m0_addr = 32'h300;
    tick();
    check("bw.owner", 32'(owner), 32'd0);
    mc_ack = 1'b1; tick();
    mc_ack = 1'b0; m0_req = 1'b0;
    m1_req = 1'b1; m1_rwn = 1'b1; m1_burst = 1'b0; m1_addr = 32'h440;
    for (int unsigned k = 0; k < 8; k++) begin
      mc_txd_ack = 1'b1; settle();
      check("bw.busy",     32'(busy), 32'd1);
      check("bw.mc_req",   32'(mc_req), 32'd0);
      check("bw.m0_txack", 32'(m0_txd_ack), 32'd1);
      tick();
    end
    mc_txd_ack = 1'b0;
    // one IDLE cycle; stray read-valid here must be dropped and flagged
    mc_rxd_vld = 1'b1; settle();
    check("bw.idle",     32'(busy), 32'd0);
    check("pe.idle_vld", 32'({m0_rxd_vld, m1_rxd_vld}), 32'd0);
    check("pe.pre",      32'(proto_err), 32'd0);
    tick();                                     // m1 granted
    mc_rxd_vld = 1'b0; settle();
    check("bw.m1_grant", 32'(owner), 32'd1);
    check("bw.m1_req",   32'(mc_req), 32'd1);
    check("pe.set",      32'(proto_err), 32'd1);
    mc_ack = 1'b1; tick();
    mc_ack = 1'b0; m1_req = 1'b0;
    // write ack during a read: not forwarded, count untouched
    mc_txd_ack = 1'b1; settle();
    check("pe.txack_fwd", 32'({m0_txd_ack, m1_txd_ack}), 32'd0);
    tick();
    mc_txd_ack = 1'b0; settle();
    check("pe.still_busy", 32'(busy), 32'd1);
    mc_rxd = 16'h0055; mc_rxd_vld = 1'b1; settle();
    check("pe.rd_vld",   32'(m1_rxd_vld), 32'd1);
    tick();
    mc_rxd_vld = 1'b0; settle();
    check("pe.done",     32'(busy), 32'd0);
    check("pe.sticky",   32'(proto_err), 32'd1);
    tick();
    check("pe.sticky2",  32'(proto_err), 32'd1);

    // ---------------- reset mid-transfer ----------------
    m1_req = 1'b1; m1_rwn = 1'b1; m1_burst = 1'b1; m1_addr = 32'h5000;
    tick();
    mc_ack = 1'b1; tick();
    mc_ack = 1'b0; m1_req = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      mc_rxd = 16'(k + 16'h10); mc_rxd_vld = 1'b1; tick();
    end
    mc_rxd_vld = 1'b0;
    check("mr.busy_pre", 32'(busy), 32'd1);
    rst = 1'b1; tick();
    rst = 1'b0; settle();
    check_reset_outputs("mr");
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    check("mr.first_owner", 32'(owner), 32'd0);
    check("mr.mc_req",      32'(mc_req), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_host_arb.md
Name:
mc_host_arb

Overview:
- Two-requester arbiter for the single host port of the HyperRAM memory controller (host_req/ack, txd/txd_ack, rxd/rxd_vld).
- Typical requesters: instruction-fetch unit (m0) and load/store unit (m1), in front of the controller.
- Round-robin arbitration; owner's command is registered and presented to the controller.
- Write/read data routed to and from the owner, words counted to detect transaction end, then the port is released.

Parameters:
BURST_WORDS, 8, number of 16-bit words moved by a burst transaction (host_burst=1); single transaction moves 1 word.
CNT_W, 4, word-counter width; must satisfy 2^CNT_W > BURST_WORDS.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
m0_req, m1_req  input  1 each  transaction request, held until matching ack
m0_rwn, m1_rwn  input  1 each  1=read, 0=write
m0_burst, m1_burst  input  1 each  1=BURST_WORDS words, 0=single word
m0_addr, m1_addr  input  32 each  word address
m0_ack, m1_ack  output  1 each  command accepted by controller
m0_txm, m1_txm  input  2 each  write byte mask
m0_txd, m1_txd  input  16 each  write data
m0_txd_ack, m1_txd_ack  output  1 each  write word consumed
m0_rxd, m1_rxd  output  16 each  read data (broadcast)
m0_rxd_vld, m1_rxd_vld  output  1 each  read word valid
mc_req  output  1  to controller host_req
mc_rwn  output  1  to host_rwn
mc_burst  output  1  to host_burst
mc_addr  output  32  to host_addr
mc_ack  input  1  from host_ack
mc_txm  output  2  to host_txm
mc_txd  output  16  to host_txd
mc_txd_ack  input  1  from host_txd_ack
mc_rxd  input  16  from host_rxd
mc_rxd_vld  input  1  from host_rxd_vld
owner  output  1  current/last granted requester
busy  output  1  state != IDLE
proto_err  output  1  sticky protocol-violation flag

Behaviour:
- States: IDLE, CMD, XFER.
- Reset:
  - state=IDLE, last=1 (so m0 wins first), owner=0, cnt=0, proto_err=0.
  - mc_req=0, mc_rwn=1, mc_burst=0, mc_addr=0.
  - All mN_ack/txd_ack/rxd_vld=0.
  - Reset mid-transaction abandons it immediately; the controller is reset alongside.
- IDLE:
  - Only m0_req -> grant 0; only m1_req -> grant 1; both -> grant !last.
  - On grant: owner<=g, last<=g, latch rwn/burst/addr of g into mc_rwn/mc_burst/mc_addr.
  - cnt<=burst?BURST_WORDS:1. Next state CMD.
- CMD:
  - mc_req=1 (combinational from state).
  - mc_ack is routed combinationally to m[owner]_ack; the other ack stays 0.
  - On mc_ack -> XFER.
  - Grant-to-mc_req latency is 1 cycle.
  - Requester deasserts req the cycle after its ack. The arbiter does not watch req after grant; withdrawal is ignored.
- XFER:
  - mc_req=0.
  - mc_txd/mc_txm = m[owner]_txd/txm, muxed combinationally; 0 when IDLE.
  - mc_txd_ack -> m[owner]_txd_ack.
  - mc_rxd is driven to both mN_rxd at all times; mc_rxd_vld -> m[owner]_rxd_vld only.
  - Write (mc_rwn=0): cnt decrements on mc_txd_ack. Read: cnt decrements on mc_rxd_vld.
  - Event with cnt==1 -> IDLE next cycle.
  - Minimum one IDLE cycle between transactions; back-to-back requests from the same master alternate only if the other master is requesting.
- Protocol rules:
  - Controller never asserts data events in the ack cycle.
  - Data events outside XFER are not forwarded and set proto_err.
  - mc_txd_ack during a read, or mc_rxd_vld during a write, also sets proto_err and does not decrement cnt.
  - mc_ack outside CMD sets proto_err.
  - proto_err clears only on rst.
- Fairness: with both requesting continuously, grants alternate 0,1,0,1; no starvation.
- Simultaneous: a new request arriving in the cycle a transaction ends waits in IDLE and is granted on the following edge.

Test Plan:
- After reset, m0 single write addr=0x100 txd=0xA5A5 txm=2'b11 -> mc_req high 1 cycle after grant, m0_ack with mc_ack, one m0_txd_ack, mc_txd=0xA5A5, back to IDLE, m1 outputs all 0.
- m1 burst read addr=0x2000, controller returns 8 words 0x0001..0x0008 -> m1_rxd_vld pulses 8 times with matching m1_rxd, m0_rxd_vld stays 0, busy drops after 8th word.
- m0 and m1 requesting in the same cycle from reset, both held continuously -> grant order 0,1,0,1 (owner toggles per transaction).
- m1 requests while m0 burst write is in XFER -> m1 not acked until m0's 8th txd_ack, then granted after one IDLE cycle.
- mc_rxd_vld pulsed in IDLE, and mc_txd_ack during a read -> neither forwarded, cnt unchanged, proto_err=1 until rst.
- rst asserted in XFER after 3 of 8 read words -> next cycle busy=0, all outputs at reset values, next simultaneous request granted to m0.
